// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Program counter and fetch sequencer for the instruction ROM.
//               It sequences IDLE -> RUN -> HALT and applies PC-relative
//               branches when the decoder flags a branch and the ALU reports
//               a taken condition.
// Revision    : 1.0 - initial release
//
// Ports
//   i_clk        : clock; all state updates on the rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_start      : level request; held high keeps PC at 0, falling edge
//                  launches execution
//   i_branch_en  : current instruction is a branch (from the decoder)
//   i_taken      : ALU condition flag for the current branch
//   i_offset     : signed branch displacement relative to the current PC
//   i_ack        : current instruction is the done instruction
//   i_stall      : freeze the PC for this cycle
//   o_pc         : instruction ROM address
//   o_running    : unit is in RUN
//   o_done       : program finished; held until the next start request
//   o_cycle_cnt  : RUN cycle counter (only with FETCH_CYCLE_CNT_EN defined)
//
// Build option
//   FETCH_CYCLE_CNT_EN : adds o_cycle_cnt, a saturating 16-bit count of RUN
//                        cycles (stalls included), cleared on entry to IDLE
//                        and frozen in HALT.
// ============================================================================
module instr_fetch #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_branch_en,
  input  logic              i_taken,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic              i_ack,
  input  logic              i_stall,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_running,
  output logic              o_done
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0]       o_cycle_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // The offset is sign-extended to whichever is wider, then cut to PC_W so
  // that the branch target is naturally taken modulo 2^PC_W.
  localparam int EXT_W = (PC_W > OFF_W) ? PC_W : OFF_W;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic             r_start_d;
  logic             w_start_fall;
  logic [EXT_W-1:0] w_off_ext;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_br;

  assign w_start_fall = r_start_d & ~i_start;
  assign w_off_ext    = EXT_W'($signed(i_offset));
  assign w_pc_inc     = r_pc + PC_W'(1);
  assign w_pc_br      = r_pc + w_off_ext[PC_W-1:0];

  // State and start-edge registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= i_start;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_fall) w_state_nxt = S_RUN;
      S_RUN: begin
        if (i_start)    w_state_nxt = S_IDLE;
        else if (i_ack) w_state_nxt = S_HALT;
      end
      S_HALT:  if (i_start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode straight from the state register keeps these glitch-free
  always_comb begin
    o_running = (r_state == S_RUN);
    o_done    = (r_state == S_HALT);
  end

  // Next-PC selection; in RUN the priority is start > ack > stall > branch
  always_comb begin
    w_pc_nxt = r_pc;
    case (r_state)
      S_RUN: begin
        if (i_start)                      w_pc_nxt = '0;
        else if (i_ack || i_stall)        w_pc_nxt = r_pc;
        else if (i_branch_en && i_taken)  w_pc_nxt = w_pc_br;
        else                              w_pc_nxt = w_pc_inc;
      end
      S_HALT:  if (i_start) w_pc_nxt = '0;
      default: w_pc_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pc <= '0;
    else          r_pc <= w_pc_nxt;
  end

  assign o_pc = r_pc;

`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] r_cycle_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt <= '0;
    end else if (w_state_nxt == S_IDLE) begin
      r_cycle_cnt <= '0;
    end else if ((r_state == S_RUN) && (r_cycle_cnt != 16'hFFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Bench for instr_fetch. Two instances (PC_W=10 and PC_W=4)
//               share one stimulus stream; a behavioural model tracks the
//               expected PC/mode/count for each width.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       br = 1'b0;
  logic       tk = 1'b0;
  logic [7:0] off = 8'h00;
  logic       ack = 1'b0;
  logic       stall = 1'b0;

  logic [9:0] pc_a;
  logic [3:0] pc_b;
  logic       run_a, run_b, done_a, done_b;
`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_W(10), .OFF_W(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_branch_en(br),
    .i_taken(tk), .i_offset(off), .i_ack(ack), .i_stall(stall),
    .o_pc(pc_a), .o_running(run_a), .o_done(done_a)
`ifdef FETCH_CYCLE_CNT_EN
    , .o_cycle_cnt(cnt_a)
`endif
  );

  instr_fetch #(.PC_W(4), .OFF_W(8)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_branch_en(br),
    .i_taken(tk), .i_offset(off), .i_ack(ack), .i_stall(stall),
    .o_pc(pc_b), .o_running(run_b), .o_done(done_b)
`ifdef FETCH_CYCLE_CNT_EN
    , .o_cycle_cnt(cnt_b)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0: PC_W=10, 1: PC_W=4) -------
  // mode: 0 idle, 1 run, 2 halt
  int m_mode [2];
  int m_pc   [2];
  int m_cnt  [2];
  int m_w    [2] = '{10, 4};
  bit m_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_pc[i] = 0; m_cnt[i] = 0;
      end
      m_prev = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int msk;
        msk = (1 << m_w[i]) - 1;
        if (m_mode[i] == 0) begin
          m_pc[i] = 0;
          if (m_prev && !start) m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
          if (start) begin
            m_mode[i] = 0; m_pc[i] = 0; m_cnt[i] = 0;
          end else begin
            if (m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
            if (ack)             m_mode[i] = 2;
            else if (stall)      ;
            else if (br && tk)   m_pc[i] = (m_pc[i] + int'($signed(off))) & msk;
            else                 m_pc[i] = (m_pc[i] + 1) & msk;
          end
        end else begin
          if (start) begin
            m_mode[i] = 0; m_pc[i] = 0; m_cnt[i] = 0;
          end
        end
      end
      m_prev = start;
    end
  end

  // Compare every cycle, away from the rising edge
  always @(negedge clk) begin
    check("pc_a",      int'(pc_a),   m_pc[0]);
    check("running_a", int'(run_a),  int'(m_mode[0] == 1));
    check("done_a",    int'(done_a), int'(m_mode[0] == 2));
    check("pc_b",      int'(pc_b),   m_pc[1]);
    check("running_b", int'(run_b),  int'(m_mode[1] == 1));
    check("done_b",    int'(done_b), int'(m_mode[1] == 2));
`ifdef FETCH_CYCLE_CNT_EN
    check("cnt_a", int'(cnt_a), m_cnt[0]);
    check("cnt_b", int'(cnt_b), m_cnt[1]);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12 rst_n = 1'b1;
    #1;
    check("rst_pc",      int'(pc_a),   0);
    check("rst_running", int'(run_a),  0);
    check("rst_done",    int'(done_a), 0);

    // launch: 3-cycle start pulse, then PC 0..4
    start = 1'b1; cyc(3);
    start = 1'b0; cyc(1);
    check("launch_pc",      int'(pc_a),  0);
    check("launch_running", int'(run_a), 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("seq_pc", int'(pc_a), k);
    end

    // branch taken at 20 with -5 -> 15; not taken at 20 -> 21
    cyc(16);
    check("pc20", int'(pc_a), 20);
    br = 1'b1; tk = 1'b1; off = 8'hFB; cyc(1);
    br = 1'b0; tk = 1'b0;
    check("br_taken", int'(pc_a), 15);
    cyc(5);
    br = 1'b1; tk = 1'b0; cyc(1);
    check("br_not_taken", int'(pc_a), 21);

    // jump to 7, stall two cycles
    tk = 1'b1; off = 8'hF2; cyc(1);
    br = 1'b0; tk = 1'b0;
    check("pc7", int'(pc_a), 7);
    stall = 1'b1; cyc(1);
    check("stall1", int'(pc_a), 7);
    cyc(1);
    check("stall2", int'(pc_a), 7);
    stall = 1'b0; cyc(1);
    check("after_stall", int'(pc_a), 8);

    // jump to 42, ack with branch -> halt at 42
    br = 1'b1; tk = 1'b1; off = 8'h22; cyc(1);
    check("pc42", int'(pc_a), 42);
    ack = 1'b1; stall = 1'b1; cyc(1);
    ack = 1'b0; stall = 1'b0; br = 1'b0; tk = 1'b0;
    check("halt_pc",   int'(pc_a),   42);
    check("halt_done", int'(done_a), 1);
    cyc(2);
    check("halt_hold", int'(pc_a),   42);
    check("done_hold", int'(done_a), 1);
    start = 1'b1; cyc(1);
    check("restart_pc",   int'(pc_a),   0);
    check("restart_done", int'(done_a), 0);
    check("restart_run",  int'(run_a),  0);
    start = 1'b0; cyc(1);
    check("relaunch_run", int'(run_a), 1);

    // PC_W=4 wrap and truncated branch
    cyc(15);
    check("b_pc15", int'(pc_b), 15);
    cyc(1);
    check("b_wrap", int'(pc_b), 0);
    cyc(2);
    check("b_pc2", int'(pc_b), 2);
    br = 1'b1; tk = 1'b1; off = 8'h14; cyc(1);
    check("b_br_trunc", int'(pc_b), 6);
    check("a_br_plus20", int'(pc_a), 38);

    // async reset mid-run at PC 9
    off = 8'hE3; cyc(1);
    br = 1'b0; tk = 1'b0;
    check("pc9", int'(pc_a), 9);
    #2 rst_n = 1'b0;
    #1;
    check("async_pc",  int'(pc_a),  0);
    check("async_run", int'(run_a), 0);
    #3 rst_n = 1'b1;
    cyc(3);
    check("no_resume_pc",  int'(pc_a),  0);
    check("no_resume_run", int'(run_a), 0);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 29) == 0);
      ack   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 4) == 0);
      br    = ($urandom_range(0, 3) == 0);
      tk    = $urandom_range(0, 1) != 0;
      off   = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cyc(1);
    end

    start = 1'b0; ack = 1'b0; stall = 1'b0; br = 1'b0; tk = 1'b0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and fetch-sequencing unit that sits directly upstream of the control decoder. It holds the program counter that addresses the instruction ROM, whose 9-bit output feeds the decoder, and it consumes the decoder's `BranchEn` and `Ack` outputs. It sequences start, run, and halt, and it applies relative branches when the ALU reports a taken condition.

## Interface
- `PC_W`, default 10: program counter / instruction ROM address width.
- `OFF_W`, default 8: width of the signed branch offset.
- `Clk`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-low.
- `Start`  in  1: level request from the testbench.
  - While high, the unit is held at PC 0.
  - The falling edge launches execution.
- `BranchEn`  in  1: from the decoder; the current instruction is a branch.
- `Taken`  in  1: ALU condition flag for the current branch.
- `Offset`  in  OFF_W: signed branch displacement, relative to the current PC.
- `Ack`  in  1: from the decoder; the current instruction is the done instruction (all ones).
- `Stall`  in  1: freeze the PC for this cycle (multi-cycle memory access).
- `PC`  out  PC_W: instruction ROM address.
- `Running`  out  1: the unit is in RUN.
- `Done`  out  1: the program has finished; held until the next `Start`.
- `CycleCnt`  out  16: present only with `FETCH_CYCLE_CNT_EN`.

## Operation
FSM states: IDLE, RUN, HALT.

- **IDLE:**
  - PC = 0.
  - Moves to RUN on the first cycle where `Start` is low, having previously been high (registered falling edge).
- **RUN:** next-PC priority, highest first:
  - (1) `Start` high → PC <= 0, go to IDLE.
  - (2) `Ack` high → PC holds, go to HALT.
  - (3) `Stall` high → PC holds.
  - (4) `BranchEn` && `Taken` → PC <= PC + sign_extend(`Offset`).
  - (5) otherwise → PC <= PC + 1.
- **HALT:**
  - PC frozen at the address of the done instruction.
  - `Done` = 1.
  - `Start` high → PC <= 0, `Done` <= 0, go to IDLE.
- **Arithmetic:** all PC arithmetic is modulo 2^PC_W.
  - Increment from 2^PC_W−1 wraps to 0.
  - Branch targets outside the range are truncated; no error flag.
- **Ignored inputs:** `BranchEn` with `Taken`=0 is a plain increment. `Taken` without `BranchEn` is ignored.
- **Simultaneous events:**
  - `Ack` and `BranchEn` together: `Ack` wins. The decoder should never produce both.
  - `Stall` and `Ack` together: `Ack` wins.
- **Outside RUN:** `Stall`, `BranchEn`, and `Ack` are ignored in IDLE and HALT.

## Timing
- Reset (asserted low, asynchronous): state = IDLE, PC = 0, `Running` = 0, `Done` = 0, start-edge register = 0, `CycleCnt` = 0.
- Reset asserted mid-RUN aborts immediately. Execution does not resume until a new `Start` pulse.
- PC is registered and valid one cycle after the update. The ROM and decoder are combinational, so the branch decision for the instruction at PC n sets the PC for cycle n+1. There is no delay slot.
- `Start` launch: with `Start` falling before edge k, the edge-k register sees it low. At edge k the state becomes RUN with PC = 0, so the instruction at address 0 executes in the cycle after edge k.
- `Done` rises at the edge after the cycle in which `Ack` is sampled in RUN.
- `Running` and `Done` are decoded from the state register and are glitch-free.

## Configuration
- Macro `FETCH_CYCLE_CNT_EN`.
- **Defined:**
  - `CycleCnt` port exists.
  - Clears when entering IDLE.
  - Increments every RUN cycle, including stall cycles.
  - Freezes in HALT.
  - Saturates at 16'hFFFF.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then a `Start` pulse of 3 cycles, then 5 cycles with no branch or `Ack` → PC sequence 0,1,2,3,4; `Running` = 1.
- In RUN at PC = 20, `BranchEn` = 1, `Taken` = 1, `Offset` = −5 (8'hFB) → PC = 15 next cycle. Repeat with `Taken` = 0 → PC = 21.
- PC = 7 with `Stall` high for 2 cycles → PC stays 7 for 2 cycles, then 8. With the macro defined, `CycleCnt` still advances by 2.
- `Ack` asserted at PC = 42 together with `BranchEn` = 1, `Taken` = 1 → PC stays 42, `Done` = 1 next cycle and held. A new `Start` → PC = 0, `Done` = 0, IDLE.
- PC_W = 4 with PC = 15 and no branch → PC = 0. PC = 2 with `Offset` = +20 → PC = 6 (22 mod 16).
- Reset asserted asynchronously mid-RUN at PC = 9 → PC = 0, IDLE, `Running` = 0 immediately without a clock edge. There is no run after reset deassertion until a `Start` pulse.
